risc_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide execution unit for the pipelined RISC core's EX stage.
- Generalises the core's single-cycle MUL to a multi-cycle unit supporting signed/unsigned multiply-high, divide and remainder at any XLEN.
- Uses a start/busy/done handshake so the pipeline can stall on it.
- Single clock.

---
 rtl/risc_pkg.sv | 53 +++++
 rtl/risc_muldiv_unit_if.sv | 22 ++
 rtl/risc_muldiv_step.sv | 29 ++
 rtl/risc_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_risc_muldiv_unit.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM encoding, result selectors and the op decoder.
package risc_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;
    localparam logic [2:0] OP_REMU  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,
        SEL_HI  = 2'd1,
        SEL_QUO = 2'd2,
        SEL_REM = 2'd3
    } sel_t;

    typedef struct packed {
        logic is_div;
        logic is_signed;
        sel_t sel;
    } op_dec_t;

    // Code 7 is reserved and falls through to plain MUL.
    function automatic op_dec_t decode_op(input logic [2:0] op);
        op_dec_t d;
        d.is_div    = 1'b0;
        d.is_signed = 1'b0;
        d.sel       = SEL_LO;
        case (op)
            OP_MULH:  begin d.is_signed = 1'b1; d.sel = SEL_HI; end
            OP_MULHU: begin d.sel = SEL_HI; end
            OP_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; d.sel = SEL_QUO; end
            OP_DIVU:  begin d.is_div = 1'b1; d.sel = SEL_QUO; end
            OP_REM:   begin d.is_div = 1'b1; d.is_signed = 1'b1; d.sel = SEL_REM; end
            OP_REMU:  begin d.is_div = 1'b1; d.sel = SEL_REM; end
            default:  ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/risc_muldiv_unit_if.sv
// Start/busy/done handshake between the EX stage and the muldiv unit.
interface risc_muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/risc_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module risc_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] part,
    input  logic [XLEN-1:0]   opnd,
    input  logic              is_div,
    output logic [2*XLEN-1:0] nxt
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;

    always_comb begin
        // Multiply: {acc_hi, multiplier} -- add multiplicand on LSB, shift right.
        sum   = {1'b0, part[2*XLEN-1:XLEN]} + (part[0] ? {1'b0, opnd} : '0);
        // Divide: {rem, quo} -- shift left one, then trial-subtract divisor.
        trial = part[2*XLEN-1:XLEN-1];
        diff  = trial[XLEN-1:0] - opnd;
        nxt   = {sum, part[XLEN-1:1]};
        if (is_div) begin
            if (trial >= {1'b0, opnd})
                nxt = {diff, part[XLEN-2:0], 1'b1};
            else
                nxt = {trial[XLEN-1:0], part[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/risc_muldiv_unit.sv
// Iterative multiply/divide unit: sign handling, fast paths, iteration FSM
// and registered handshake outputs around the risc_muldiv_step datapath.
module risc_muldiv_unit
    import risc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    risc_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opnd;
    logic              run_div;
    sel_t              run_sel;
    logic              neg;
    logic              dbz;

    op_dec_t           in_dec;
    logic              sa, sb, in_zero, in_ovf, start_ok;
    logic [XLEN-1:0]   mag_a, mag_b, fix_val;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        in_dec  = decode_op(bus.op);
        sa      = in_dec.is_signed & bus.a[XLEN-1];
        sb      = in_dec.is_signed & bus.b[XLEN-1];
        mag_a   = sa ? -bus.a : bus.a;
        mag_b   = sb ? -bus.b : bus.b;
        in_zero = in_dec.is_div && (bus.b == '0);
        in_ovf  = in_dec.is_div && in_dec.is_signed &&
                  (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
        // flush has priority over a new request in IDLE/DONE
        start_ok = bus.start && !bus.flush && (state == S_IDLE || state == S_DONE);
    end

    always_comb begin
        prod    = neg ? -acc : acc;
        fix_val = '0;
        case (run_sel)
            SEL_LO:  fix_val = prod[XLEN-1:0];
            SEL_HI:  fix_val = prod[2*XLEN-1:XLEN];
            SEL_QUO: fix_val = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            SEL_REM: fix_val = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            default: fix_val = '0;
        endcase
    end

    risc_muldiv_step #(.XLEN(XLEN)) u_step (
        .part   (acc),
        .opnd   (opnd),
        .is_div (run_div),
        .nxt    (acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            acc             <= '0;
            opnd            <= '0;
            run_div         <= 1'b0;
            run_sel         <= SEL_LO;
            neg             <= 1'b0;
            dbz             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (start_ok) begin
            run_div         <= in_dec.is_div;
            run_sel         <= in_dec.sel;
            opnd            <= mag_b;
            cnt             <= '0;
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            // Fast paths preload {rem, quo} and skip RUN entirely.
            if (in_zero) begin
                acc   <= {bus.a, {XLEN{1'b1}}};
                neg   <= 1'b0;
                dbz   <= 1'b1;
                state <= S_FIX;
            end else if (in_ovf) begin
                acc   <= {{XLEN{1'b0}}, bus.a};
                neg   <= 1'b0;
                dbz   <= 1'b0;
                state <= S_FIX;
            end else begin
                acc   <= {{XLEN{1'b0}}, mag_a};
                neg   <= (in_dec.sel == SEL_REM) ? sa : (sa ^ sb);
                dbz   <= 1'b0;
                state <= S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.flush) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN-1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.busy <= 1'b0;
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        state           <= S_DONE;
                        bus.done        <= 1'b1;
                        bus.result      <= fix_val;
                        bus.div_by_zero <= dbz;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_risc_muldiv_unit.sv
// Directed bench for risc_muldiv_unit at XLEN=32: latency, results,
// fast paths, back-to-back starts, flush and async reset.
module tb_risc_muldiv_unit;
    import risc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   lat, bcnt, seen;

    risc_muldiv_if #(.XLEN(32)) bus ();

    risc_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller must be at a negedge; the following posedge is edge 0.
    task automatic fire(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        fire(o, x, y);
    endtask

    // lat = edge index at which done is sampled high; bcnt = busy samples before it.
    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = 0;
        do begin
            @(negedge clk);
            l++;
            if (bus.busy) bc++;
        end while (!bus.done && l < 100);
    endtask

    task automatic run_chk(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp, input logic ez,
                           input int elat);
        issue(o, x, y);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, {32'h0, bus.result}, {32'h0, exp});
        chk({tag, "_dbz"}, {63'h0, bus.div_by_zero}, {63'h0, ez});
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        #2;
        chk("rst_busy",   {63'h0, bus.busy},        64'h0);
        chk("rst_done",   {63'h0, bus.done},        64'h0);
        chk("rst_result", {32'h0, bus.result},      64'h0);
        chk("rst_dbz",    {63'h0, bus.div_by_zero}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // MUL 7*6: busy sampled at edges 1..33, done at 34, single pulse
        issue(OP_MUL, 32'd7, 32'd6);
        wait_done(lat, bcnt);
        chk("mul_lat",  64'(lat),  64'd34);
        chk("mul_busy", 64'(bcnt), 64'd33);
        chk("mul_res",  {32'h0, bus.result}, 64'd42);
        @(negedge clk);
        chk("mul_pulse", {63'h0, bus.done}, 64'h0);

        run_chk("mulh",  OP_MULH,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 34);
        run_chk("mulhu", OP_MULHU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 1'b0, 34);
        run_chk("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34);
        run_chk("rem",   OP_REM,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34);
        run_chk("divu",  OP_DIVU,  32'd100, 32'd7, 32'd14, 1'b0, 34);
        run_chk("remu",  OP_REMU,  32'd100, 32'd7, 32'd2,  1'b0, 34);
        run_chk("mul_u", 3'd7,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 34);

        // Fast paths
        run_chk("divu0", OP_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b1, 2);
        run_chk("rem0",  OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, 2);
        run_chk("ovfd",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2);
        run_chk("ovfr",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 2);

        // Factorial chain, each start in the DONE cycle, with a junk start mid-RUN
        issue(OP_MUL, 32'd4, 32'd3);
        wait_done(lat, bcnt);
        chk("fact1", {32'h0, bus.result}, 64'd12);
        fire(OP_MUL, bus.result, 32'd2);
        repeat (5) @(posedge clk);
        #1 bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd99; bus.b = 32'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcnt);
        chk("fact2_lat", 64'(lat + 6), 64'd34);
        chk("fact2", {32'h0, bus.result}, 64'd24);
        fire(OP_MUL, bus.result, 32'd1);
        wait_done(lat, bcnt);
        chk("fact3_lat", 64'(lat), 64'd34);
        chk("fact3", {32'h0, bus.result}, 64'd24);

        // flush wins over start in IDLE
        @(negedge clk);
        bus.flush = 1'b1;
        fire(OP_MUL, 32'd2, 32'd2);
        bus.flush = 1'b0;
        chk("flush_idle", {63'h0, bus.busy}, 64'h0);

        // flush during a DIV: sampled at edge 11, no done afterwards
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_flush_busy", {63'h0, bus.busy}, 64'h1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        chk("flush_busy", {63'h0, bus.busy}, 64'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("flush_nodone", 64'(seen), 64'h0);
        chk("flush_res", {32'h0, bus.result}, 64'd24);

        // Async reset mid-RUN clears outputs without a clock edge
        issue(OP_MUL, 32'd5, 32'd5);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy",   {63'h0, bus.busy},   64'h0);
        chk("arst_done",   {63'h0, bus.done},   64'h0);
        chk("arst_result", {32'h0, bus.result}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_chk("post_rst", OP_MUL, 32'd5, 32'd5, 32'd25, 1'b0, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
